// File: rtl/sram_arbiter_pkg.sv
// ============================================================================
// Module  : sram_arbiter_pkg
// Brief   : Shared state encoding, grant IDs and default widths for sram_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package sram_arbiter_pkg;

    localparam int DEF_ADDR_W = 18;
    localparam int DEF_DATA_W = 16;
    localparam int CNT_W      = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_DONE   = 2'd2;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_D  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/sram_arbiter_rr_arb2.sv
// ============================================================================
// Module  : rr_arb2
// Brief   : Combinational two-way round-robin pick between fetch and data ports
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
    input  logic req_if_i,
    input  logic req_d_i,
    input  logic last_grant_i,
    output logic grant_o,
    output logic valid_o
);
    import sram_arbiter_pkg::*;

    always_comb begin
        valid_o = req_if_i | req_d_i;
        grant_o = GNT_IF;
        if (req_if_i && req_d_i) begin
            grant_o = ~last_grant_i;
        end else if (req_d_i) begin
            grant_o = GNT_D;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sram_arbiter.sv
// ============================================================================
// Module  : sram_arbiter
// Brief   : Shares one async SRAM between fetch and data ports, timed strobes
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              gnt_q, gnt_d;
    logic              op_we_q, op_we_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0] sram_dq_o_q, sram_dq_o_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              dq_oe_q, dq_oe_d;
    logic              busy_q, busy_d;
    logic              arb_grant;
    logic              arb_valid;
    logic              capture;

    rr_arb2 u_rr_arb2 (
        .req_if_i     (if_req),
        .req_d_i      (d_req),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .valid_o      (arb_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= GNT_IF;
            gnt_q        <= GNT_IF;
            op_we_q      <= 1'b0;
            sram_addr_q  <= '0;
            sram_dq_o_q  <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            ce_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            dq_oe_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            op_we_q      <= op_we_d;
            sram_addr_q  <= sram_addr_d;
            sram_dq_o_q  <= sram_dq_o_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            if_ack_q     <= if_ack_d;
            d_ack_q      <= d_ack_d;
            ce_n_q       <= ce_n_d;
            oe_n_q       <= oe_n_d;
            we_n_q       <= we_n_d;
            dq_oe_q      <= dq_oe_d;
            busy_q       <= busy_d;
        end
    end

    // Requests are only looked at in IDLE; an access in flight always runs to DONE.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        op_we_d      = op_we_q;
        sram_addr_d  = sram_addr_q;
        sram_dq_o_d  = sram_dq_o_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_d      = ST_ACCESS;
                    cnt_d        = CNT_INIT;
                    gnt_d        = arb_grant;
                    last_grant_d = arb_grant;
                    if (arb_grant == GNT_D) begin
                        sram_addr_d = d_addr;
                        op_we_d     = d_we;
                        sram_dq_o_d = d_wdata;
                    end else begin
                        sram_addr_d = if_addr;
                        op_we_d     = 1'b0;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes follow the upcoming state so they line up with the registered state.
    always_comb begin
        capture    = (state_q == ST_ACCESS) && (cnt_q == '0) && !op_we_q;
        ce_n_d     = !(state_d == ST_ACCESS);
        oe_n_d     = !((state_d == ST_ACCESS) && !op_we_d);
        we_n_d     = !((state_d == ST_ACCESS) && op_we_d);
        dq_oe_d    = ((state_d == ST_ACCESS) || (state_d == ST_DONE)) && op_we_d;
        if_ack_d   = (state_d == ST_DONE) && (gnt_d == GNT_IF);
        d_ack_d    = (state_d == ST_DONE) && (gnt_d == GNT_D);
        busy_d     = (state_d != ST_IDLE);
        if_rdata_d = (capture && (gnt_q == GNT_IF)) ? sram_dq_i : if_rdata_q;
        d_rdata_d  = (capture && (gnt_q == GNT_D))  ? sram_dq_i : d_rdata_q;
    end

    assign if_rdata   = if_rdata_q;
    assign if_ack     = if_ack_q;
    assign d_rdata    = d_rdata_q;
    assign d_ack      = d_ack_q;
    assign sram_addr  = sram_addr_q;
    assign sram_dq_o  = sram_dq_o_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// ============================================================================
// Module  : tb_sram_arbiter
// Brief   : Scoreboarded random/directed bench for sram_arbiter with SRAM model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sram_arbiter;

    localparam int WT      = 2;
    localparam int WT1     = 1;
    localparam int LAT_MAX = 2 * WT + 4;

    typedef struct packed {
        logic        we;
        logic [17:0] addr;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        if_req = 1'b0;
    logic [17:0] if_addr = '0;
    logic [15:0] if_rdata;
    logic        if_ack;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [17:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic [15:0] d_rdata;
    logic        d_ack;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_o;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_i = '0;
    logic        sram_ce_n, sram_oe_n, sram_we_n, busy;

    logic        if_req1 = 1'b0;
    logic [17:0] if_addr1 = '0;
    logic [15:0] if_rdata1, d_rdata1, sram_dq_o1;
    logic        if_ack1, d_ack1, sram_dq_oe1;
    logic [17:0] sram_addr1;
    logic [15:0] sram_dq_i1 = '0;
    logic        sram_ce_n1, sram_oe_n1, sram_we_n1, busy1;

    int          checks = 0;
    int          errors = 0;
    int          viol = 0;
    int          cnt_oe = 0, cnt_we = 0, cnt_dqoe = 0;
    int          sram_low = 0;
    int          lat_if, lat_d, n1;
    int          g_if, g_d;
    logic [17:0] a_if, a_d;
    logic        we_r;
    logic [15:0] wd_r;
    exp_t        q_if[$];
    exp_t        q_d[$];
    logic        exp_order[$];
    logic [15:0] phys_wr[logic [17:0]];
    logic [15:0] ref_wr[logic [17:0]];

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(WT)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
        .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .busy(busy)
    );

    sram_arbiter #(.ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(WT1)) u_dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ack(if_ack1),
        .d_req(1'b0), .d_we(1'b0), .d_addr(18'h0), .d_wdata(16'h0),
        .d_rdata(d_rdata1), .d_ack(d_ack1),
        .sram_addr(sram_addr1), .sram_dq_o(sram_dq_o1), .sram_dq_oe(sram_dq_oe1),
        .sram_dq_i(sram_dq_i1), .sram_ce_n(sram_ce_n1), .sram_oe_n(sram_oe_n1),
        .sram_we_n(sram_we_n1), .busy(busy1)
    );

    function automatic logic [15:0] init_val(input logic [17:0] a);
        if (a == 18'h00010) return 16'h4A21;
        return a[15:0] ^ 16'hC3A5 ^ {14'd0, a[17:16]};
    endfunction

    function automatic logic [15:0] phys_rd(input logic [17:0] a);
        return phys_wr.exists(a) ? phys_wr[a] : init_val(a);
    endfunction

    function automatic logic [15:0] ref_rd(input logic [17:0] a);
        return ref_wr.exists(a) ? ref_wr[a] : init_val(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_if(input logic [17:0] a, output int lat);
        exp_t e;
        if_req  = 1'b1;
        if_addr = a;
        e.we = 1'b0; e.addr = a; e.data = ref_rd(a);
        q_if.push_back(e);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!if_ack && lat < 100);
        if (!if_ack) chk("if_ack_timeout", {31'd0, if_ack}, 32'd1);
    endtask

    task automatic do_d(input logic we, input logic [17:0] a, input logic [15:0] wd,
                        output int lat);
        exp_t e;
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
        e.we = we; e.addr = a;
        if (we) begin
            ref_wr[a] = wd;
            e.data = wd;
        end else begin
            e.data = ref_rd(a);
        end
        q_d.push_back(e);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!d_ack && lat < 100);
        if (!d_ack) chk("d_ack_timeout", {31'd0, d_ack}, 32'd1);
    endtask

    // Async SRAM: reads follow OE_n; a write commits only once WE_n has been low WT cycles.
    initial forever begin
        @(negedge clk);
        sram_dq_i  = sram_oe_n  ? 16'hDEAD : phys_rd(sram_addr);
        sram_dq_i1 = sram_oe_n1 ? 16'hDEAD : phys_rd(sram_addr1);
        if (!sram_ce_n && !sram_we_n) begin
            sram_low++;
            if (sram_low == WT) phys_wr[sram_addr] = sram_dq_o;
        end else begin
            sram_low = 0;
        end
    end

    initial forever begin
        exp_t e;
        logic eo;
        @(negedge clk);
        if (!sram_oe_n && !sram_we_n)   viol++;
        if (sram_dq_oe && !sram_oe_n)   viol++;
        if (if_ack && d_ack)            viol++;
        if (!sram_oe_n1 && !sram_we_n1) viol++;
        if (sram_dq_oe1 && !sram_oe_n1) viol++;
        if (if_ack1 && d_ack1)          viol++;
        if (rst) begin
            cnt_oe = 0; cnt_we = 0; cnt_dqoe = 0;
        end else begin
            if (!sram_oe_n) cnt_oe++;
            if (!sram_we_n) cnt_we++;
            if (sram_dq_oe) cnt_dqoe++;
            if ((if_ack || d_ack) && exp_order.size() > 0) begin
                eo = exp_order.pop_front();
                chk("grant_order", {31'd0, d_ack}, {31'd0, eo});
            end
            if (if_ack) begin
                if (q_if.size() == 0) begin
                    chk("if_ack_unexpected", {31'd0, if_ack}, 32'd0);
                end else begin
                    e = q_if.pop_front();
                    chk("if_rdata", {16'd0, if_rdata}, {16'd0, e.data});
                    chk("if_oe_low_cycles", cnt_oe, WT);
                    chk("if_dqoe_cycles", cnt_dqoe, 0);
                end
            end
            if (d_ack) begin
                if (q_d.size() == 0) begin
                    chk("d_ack_unexpected", {31'd0, d_ack}, 32'd0);
                end else begin
                    e = q_d.pop_front();
                    if (e.we) begin
                        chk("d_write_mem", {16'd0, phys_rd(e.addr)}, {16'd0, e.data});
                        chk("d_we_low_cycles", cnt_we, WT);
                        chk("d_dqoe_cycles", cnt_dqoe, WT + 1);
                    end else begin
                        chk("d_rdata", {16'd0, d_rdata}, {16'd0, e.data});
                        chk("d_oe_low_cycles", cnt_oe, WT);
                        chk("d_dqoe_cycles", cnt_dqoe, 0);
                    end
                end
            end
            if (if_ack || d_ack) begin
                cnt_oe = 0; cnt_we = 0; cnt_dqoe = 0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_if_ack", {31'd0, if_ack}, 32'd0);
        chk("rst_d_ack", {31'd0, d_ack}, 32'd0);
        chk("rst_if_rdata", {16'd0, if_rdata}, 32'd0);
        chk("rst_d_rdata", {16'd0, d_rdata}, 32'd0);
        chk("rst_ce_n", {31'd0, sram_ce_n}, 32'd1);
        chk("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
        chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        chk("rst_addr", {14'd0, sram_addr}, 32'd0);
        chk("rst_dq_o", {16'd0, sram_dq_o}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;

        // Both ports contend from reset: data port wins first, then strict alternation.
        exp_order.push_back(1'b1); exp_order.push_back(1'b0);
        exp_order.push_back(1'b1); exp_order.push_back(1'b0);
        exp_order.push_back(1'b1); exp_order.push_back(1'b0);
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    do_d(1'b1, 18'h20000 + 18'(k), 16'hA000 + 16'(k), lat_d);
                    if (k == 0) chk("contend_d_first_lat", lat_d, WT + 1);
                    chk("contend_d_wait", {31'd0, lat_d <= LAT_MAX}, 32'd1);
                end
                d_req = 1'b0;
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    do_if(18'h00040 + 18'(k), lat_if);
                    if (k == 0) chk("contend_if_first_lat", lat_if, 2 * WT + 3);
                    chk("contend_if_wait", {31'd0, lat_if <= LAT_MAX}, 32'd1);
                end
                if_req = 1'b0;
            end
        join
        repeat (4) @(negedge clk);

        do_if(18'h00010, lat_if);
        chk("single_if_lat", lat_if, WT + 1);
        chk("single_if_data", {16'd0, if_rdata}, 32'h4A21);
        chk("single_if_no_d_ack", {31'd0, d_ack}, 32'd0);
        if_req = 1'b0;
        repeat (2) @(negedge clk);

        do_d(1'b1, 18'h0BF00, 16'h1234, lat_d);
        chk("single_wr_lat", lat_d, WT + 1);
        chk("single_wr_dq_oe_in_done", {31'd0, sram_dq_oe}, 32'd1);
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("single_wr_mem", {16'd0, phys_rd(18'h0BF00)}, 32'h1234);
        chk("single_wr_dq_oe_released", {31'd0, sram_dq_oe}, 32'd0);

        fork
            begin
                for (int k = 0; k < 25; k++) begin
                    a_if = 18'($urandom_range(0, 255));
                    do_if(a_if, lat_if);
                    chk("rand_if_wait", {31'd0, lat_if <= LAT_MAX}, 32'd1);
                    g_if = $urandom_range(0, 3);
                    if (g_if > 0) begin
                        if_req = 1'b0;
                        repeat (g_if) @(negedge clk);
                    end
                end
                if_req = 1'b0;
            end
            begin
                for (int k = 0; k < 25; k++) begin
                    a_d  = 18'h20000 + 18'($urandom_range(0, 31));
                    we_r = 1'($urandom_range(0, 1));
                    wd_r = 16'($urandom);
                    do_d(we_r, a_d, wd_r, lat_d);
                    chk("rand_d_wait", {31'd0, lat_d <= LAT_MAX}, 32'd1);
                    g_d = $urandom_range(0, 3);
                    if (g_d > 0) begin
                        d_req = 1'b0;
                        repeat (g_d) @(negedge clk);
                    end
                end
                d_req = 1'b0;
            end
        join
        repeat (6) @(negedge clk);

        // Reset lands in the first write-strobe cycle: the write must be abandoned.
        d_req = 1'b1; d_we = 1'b1; d_addr = 18'h30000; d_wdata = 16'hBEEF;
        n1 = 0;
        do begin @(negedge clk); n1++; end while (sram_we_n && n1 < 10);
        chk("midrst_reached_access", {31'd0, sram_we_n}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        d_req = 1'b0;
        chk("midrst_ce_n", {31'd0, sram_ce_n}, 32'd1);
        chk("midrst_oe_n", {31'd0, sram_oe_n}, 32'd1);
        chk("midrst_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("midrst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_no_ack", {31'd0, d_ack}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrst_mem_unchanged", {16'd0, phys_rd(18'h30000)}, {16'd0, init_val(18'h30000)});

        // Single-cycle strobe instance: back-to-back fetches at 0 and 1.
        if_req1 = 1'b1; if_addr1 = 18'h0;
        n1 = 0;
        do begin @(negedge clk); n1++; end while (!if_ack1 && n1 < 50);
        chk("w1_first_lat", n1, WT1 + 1);
        chk("w1_data0", {16'd0, if_rdata1}, {16'd0, init_val(18'h0)});
        if_addr1 = 18'h1;
        n1 = 0;
        do begin @(negedge clk); n1++; end while (!if_ack1 && n1 < 50);
        chk("w1_ack_spacing", n1, WT1 + 2);
        chk("w1_data1", {16'd0, if_rdata1}, {16'd0, init_val(18'h1)});
        chk("w1_no_d_ack", {31'd0, d_ack1}, 32'd0);
        if_req1 = 1'b0;
        repeat (4) @(negedge clk);

        chk("bus_safety_violations", viol, 0);
        chk("scoreboard_drained", q_if.size() + q_d.size() + exp_order.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
